wb_src_arbiter: RTL

- Round-robin arbiter that shares the 9-input, 32-bit write-back source multiplexer between up to nine requesters (e.g. ALU, shifter, mult/div HI/LO, memory load, PC+4, immediate).
- Drives the multiplexer's 4-bit select and a one-hot grant.
- Holds the selection stable until the downstream consumer accepts.
- Sits between the requesting datapath units and the register-file / memory write-back port.

---
 rtl/wb_src_arbiter_if.sv | 24 ++
 rtl/wb_src_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/wb_src_arbiter_if.sv
// Bus between the write-back requesters, the source-mux arbiter and the write-back consumer.
// master = arbiter side (drives grant/select/valid/count), slave = requester/consumer side.
interface wb_src_arbiter_if #(
    parameter int N_REQ = 9,
    parameter int SEL_W = 4,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0] req;
    logic             wb_ready;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             wb_valid;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        input  req, wb_ready,
        output gnt, sel, wb_valid, xfer_count
    );

    modport slave (
        output req, wb_ready,
        input  gnt, sel, wb_valid, xfer_count
    );
endinterface

// File: rtl/wb_src_arbiter.sv
// Round-robin arbiter for the write-back source multiplexer: registered one-hot grant,
// binary select and valid, held until the consumer accepts; counts completed transfers.
module wb_src_arbiter #(
    parameter int N_REQ = 9,
    parameter int SEL_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    wb_src_arbiter_if.master bus,
    output logic             dbg_busy_o,
    output logic [SEL_W-1:0] dbg_ptr_o
);

    // Handshake: a transfer completes on a rising edge where wb_valid=1 and wb_ready=1.
    // While wb_valid=1 and wb_ready=0, gnt/sel/wb_valid stay put unless the granted req drops.

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] ptr_q;

    logic [SEL_W-1:0] ptr_d;
    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] arb_ptr;
    logic [SEL_W:0]   win;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [N_REQ-1:0] gnt_d;

    // First set bit of cand at or above start, wrapping past N_REQ-1 back to 0.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] c,
                                               input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(N_REQ)) sum = sum - (SEL_W + 1)'(N_REQ);
            idx = sum[SEL_W-1:0];
            if (c[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        ptr_d = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
        if (state_q == IDLE) begin
            cand    = bus.req;
            arb_ptr = ptr_q;
        end else begin
            // The requester just served is masked for this one re-arbitration.
            cand    = bus.req & ~gnt_q;
            arb_ptr = ptr_d;
        end
        win       = rr_pick(cand, arb_ptr);
        win_found = win[SEL_W];
        win_idx   = win[SEL_W-1:0];
        gnt_d     = N_REQ'(1) << win_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q <= BUSY;
                        gnt_q   <= gnt_d;
                        sel_q   <= win_idx;
                        valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.wb_ready) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        ptr_q <= ptr_d;
                        if (win_found) begin
                            gnt_q <= gnt_d;
                            sel_q <= win_idx;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            valid_q <= 1'b0;
                        end
                    end else if ((bus.req & gnt_q) == '0) begin
                        // Granted requester withdrew before acceptance; sel keeps its value.
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.wb_valid   = valid_q;
    assign bus.xfer_count = cnt_q;
    assign dbg_busy_o     = (state_q == BUSY);
    assign dbg_ptr_o      = ptr_q;

endmodule
